// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the 5-stage RISC-V pipeline control blocks.
package riscv_pipe_pkg;

    localparam logic [1:0] FWD_RD      = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    localparam logic [1:0] RES_SRC_MEM = 2'b01;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_WAIT     = 1'b1;

    // Memory-stage result is newer than writeback, so it wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [4:0] rd_w,
        input logic       rw_m,
        input logic       rw_w
    );
        if (rw_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (rw_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RD;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand-forwarding select generation for the Execute stage (combinational).
module forward_unit
    import riscv_pipe_pkg::*;
(
    input  logic [4:0] i_rs1_e,
    input  logic [4:0] i_rs2_e,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    output logic [1:0] o_forward_a,
    output logic [1:0] o_forward_b
);

    assign o_forward_a = fwd_sel(i_rs1_e, i_rd_m, i_rd_w, i_reg_write_m, i_reg_write_w);
    assign o_forward_b = fwd_sel(i_rs2_e, i_rd_m, i_rd_w, i_reg_write_m, i_reg_write_w);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: forwarding, load-use stall, branch flush,
// memory wait-state freeze and saturating stall/flush counters.
module pipeline_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             cnt_clr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [0:0]       o_dbg_state
);

    localparam int               WC_W     = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0]  WAIT_LIM = WC_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_memwait;
    logic             w_lw_stall;
    logic [1:0]       w_fa;
    logic [1:0]       w_fb;
    logic             w_stall_fd;
    logic             w_stall_em;
    logic             w_flush_d;
    logic             w_flush_e;
    logic             w_br_flush;
    logic [WC_W-1:0]  w_wait_nxt;

    logic [0:0]       r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    forward_unit u_forward_unit (
        .i_rs1_e       (Rs1E),
        .i_rs2_e       (Rs2E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_forward_a   (w_fwd_a),
        .o_forward_b   (w_fwd_b)
    );

    assign w_memwait  = MemReqM & ~MemReadyM;
    assign w_lw_stall = (ResultSrcE == RES_SRC_MEM) & RegWriteE & (RdE != 5'd0)
                      & ((RdE == Rs1D) | (RdE == Rs2D));

    // Outputs follow memwait directly so the freeze starts in the same cycle;
    // a held PCSrcE naturally produces its flush once memwait drops.
    always_comb begin
        w_fa       = w_fwd_a;
        w_fb       = w_fwd_b;
        w_stall_fd = 1'b0;
        w_stall_em = 1'b0;
        w_flush_d  = 1'b0;
        w_flush_e  = 1'b0;
        if (!rst_n) begin
            w_fa      = FWD_RD;
            w_fb      = FWD_RD;
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_memwait) begin
            w_stall_fd = 1'b1;
            w_stall_em = 1'b1;
        end else begin
            w_stall_fd = w_lw_stall & ~PCSrcE;
            w_flush_d  = PCSrcE;
            w_flush_e  = PCSrcE | w_lw_stall;
        end
    end

    assign w_br_flush = w_flush_e & PCSrcE & ~w_memwait;

    always_comb begin
        w_wait_nxt = WC_W'(1);
        if (r_state == ST_WAIT)
            w_wait_nxt = (r_wait_cnt == WAIT_LIM) ? r_wait_cnt : r_wait_cnt + WC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_memwait) begin
                r_state    <= ST_WAIT;
                r_wait_cnt <= w_wait_nxt;
                if (w_wait_nxt == WAIT_LIM)
                    r_mem_timeout <= 1'b1;
            end else begin
                r_state    <= ST_RUN;
                r_wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_fd && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_br_flush && (r_flush_cnt != CNT_MAX))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign ForwardAE   = w_fa;
    assign ForwardBE   = w_fb;
    assign StallF      = w_stall_fd;
    assign StallD      = w_stall_fd;
    assign StallE      = w_stall_em;
    assign StallM      = w_stall_em;
    assign FlushD      = w_flush_d;
    assign FlushE      = w_flush_e;
    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a queue-based scoreboard.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MemReqM, MemReadyM, cnt_clr;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [0:0] o_dbg_state;

    logic [19:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM), .cnt_clr(cnt_clr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .o_dbg_state(o_dbg_state)
    );

    // Packing: {fa, fb, stall{F,D,E,M}, flush{D,E}, timeout, state, stall_cnt, flush_cnt}
    function automatic logic [19:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic [3:0] stl, input logic [1:0] fl,
                                       input logic to, input logic st,
                                       input logic [3:0] sc, input logic [3:0] fc);
        return {fa, fb, stl, fl, to, st, sc, fc};
    endfunction

    task automatic set_defaults();
        rst_n = 1'b1;
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        set_defaults();
    endtask

    task automatic load_use();
        ResultSrcE = 2'b01; RdE = 5'd7; RegWriteE = 1'b1; Rs1D = 5'd7;
    endtask

    task automatic expect_out(input logic [19:0] e, input string name);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [19:0] e;
            logic [19:0] act;
            string       n;
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE,
                   mem_timeout, o_dbg_state, stall_cnt, flush_cnt};
            n_checks++;
            if (act === e)
                n_pass++;
            else
                $display("FAIL %s: got %05h expected %05h", n, act, e);
        end
    end

    initial begin
        set_defaults();
        rst_n = 1'b0;

        // Reset forces outputs even with live hazards on the inputs.
        cyc(); rst_n = 1'b0; Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; MemReqM = 1'b1;
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b11, 0, 0, 4'd0, 4'd0), "reset_forced");
        cyc();
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b00, 0, 0, 4'd0, 4'd0), "idle_after_reset");

        // Forwarding
        cyc(); Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
        expect_out(mk(2'b10, 2'b00, 4'b0000, 2'b00, 0, 0, 4'd0, 4'd0), "fwd_mem_priority");
        cyc(); Rs1E = 5'd5; RdM = 5'd0; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
        expect_out(mk(2'b01, 2'b00, 4'b0000, 2'b00, 0, 0, 4'd0, 4'd0), "fwd_wb_rdm_zero");
        cyc(); Rs1E = 5'd9; Rs2E = 5'd9; RdM = 5'd9; RdW = 5'd9; RegWriteW = 1'b1;
        expect_out(mk(2'b01, 2'b01, 4'b0000, 2'b00, 0, 0, 4'd0, 4'd0), "fwd_wb_both");
        cyc(); Rs1E = 5'd0; Rs2E = 5'd3; RdM = 5'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
        expect_out(mk(2'b00, 2'b10, 4'b0000, 2'b00, 0, 0, 4'd0, 4'd0), "fwd_b_mem_x0_a");

        // Load-use stall for a single cycle
        cyc(); ResultSrcE = 2'b01; RdE = 5'd7; RegWriteE = 1'b1; Rs2D = 5'd7;
        expect_out(mk(2'b00, 2'b00, 4'b1100, 2'b01, 0, 0, 4'd0, 4'd0), "lw_stall");
        cyc();
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b00, 0, 0, 4'd1, 4'd0), "lw_released_cnt1");
        cyc(); ResultSrcE = 2'b01; RdE = 5'd0; RegWriteE = 1'b1; Rs1D = 5'd0;
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b00, 0, 0, 4'd1, 4'd0), "lw_rd_x0");
        cyc(); ResultSrcE = 2'b10; RdE = 5'd7; RegWriteE = 1'b1; Rs1D = 5'd7;
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b00, 0, 0, 4'd1, 4'd0), "non_load_no_stall");

        // Branch beats load-use
        cyc(); load_use(); PCSrcE = 1'b1;
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b11, 0, 0, 4'd1, 4'd0), "pc_over_lw");
        cyc();
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b00, 0, 0, 4'd1, 4'd1), "flush_cnt1");

        // Memory wait with a pending branch
        for (int i = 0; i < 3; i++) begin
            cyc(); MemReqM = 1'b1; PCSrcE = 1'b1;
            expect_out(mk(2'b00, 2'b00, 4'b1111, 2'b00, 0, (i != 0), 4'(1 + i), 4'd1), "memwait_pc");
        end
        cyc(); MemReqM = 1'b1; MemReadyM = 1'b1; PCSrcE = 1'b1;
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b11, 0, 1, 4'd4, 4'd1), "release_flush");
        cyc();
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b00, 0, 0, 4'd4, 4'd2), "back_to_run");

        // Timeout after four wait cycles, sticky past release
        for (int i = 0; i < 5; i++) begin
            cyc(); MemReqM = 1'b1;
            expect_out(mk(2'b00, 2'b00, 4'b1111, 2'b00, (i == 4), (i != 0), 4'(4 + i), 4'd2), "timeout_wait");
        end
        cyc(); MemReqM = 1'b1; MemReadyM = 1'b1;
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b00, 1, 1, 4'd9, 4'd2), "timeout_ready");
        cyc();
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b00, 1, 0, 4'd9, 4'd2), "timeout_sticky");

        // Reset in the middle of a wait
        cyc(); MemReqM = 1'b1;
        expect_out(mk(2'b00, 2'b00, 4'b1111, 2'b00, 1, 0, 4'd9, 4'd2), "pre_reset_wait0");
        cyc(); MemReqM = 1'b1;
        expect_out(mk(2'b00, 2'b00, 4'b1111, 2'b00, 1, 1, 4'd10, 4'd2), "pre_reset_wait1");
        cyc(); rst_n = 1'b0; MemReqM = 1'b1;
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b11, 0, 0, 4'd0, 4'd0), "reset_mid_wait");
        cyc();
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b00, 0, 0, 4'd0, 4'd0), "after_mid_reset");

        // Stall counter saturation, then clear beating a same-cycle event
        for (int k = 0; k < 17; k++) begin
            cyc(); load_use();
            expect_out(mk(2'b00, 2'b00, 4'b1100, 2'b01, 0, 0, (k > 15) ? 4'd15 : 4'(k), 4'd0), "stall_sat");
        end
        cyc(); load_use(); cnt_clr = 1'b1;
        expect_out(mk(2'b00, 2'b00, 4'b1100, 2'b01, 0, 0, 4'd15, 4'd0), "clr_with_stall");
        cyc(); PCSrcE = 1'b1; cnt_clr = 1'b1;
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b11, 0, 0, 4'd0, 4'd0), "clr_with_flush");
        cyc(); PCSrcE = 1'b1;
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b11, 0, 0, 4'd0, 4'd0), "flush_after_clr");
        cyc();
        expect_out(mk(2'b00, 2'b00, 4'b0000, 2'b00, 0, 0, 4'd0, 4'd1), "flush_cnt_counts");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage RISC-V pipeline.
- Generates operand-forwarding selects for Execute and stall/flush controls for the IF/ID, ID/EX and EX/MEM registers, including the FlushE bubble insertion on the decode-to-execute register.
- Adds a wait-state FSM that freezes the pipeline while the data memory is not ready.
- Keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.
- WAIT_MAX, 64, consecutive memory-wait cycles after which mem_timeout is set.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; asynchronous, active-low
- Rs1D  in  5  rs1 of the instruction in Decode
- Rs2D  in  5  rs2 of the instruction in Decode
- Rs1E  in  5  rs1 of the instruction in Execute
- Rs2E  in  5  rs2 of the instruction in Execute
- RdE  in  5  rd in Execute
- RdM  in  5  rd in Memory
- RdW  in  5  rd in Writeback
- RegWriteE  in  1  Execute instruction writes the register file
- RegWriteM  in  1  Memory instruction writes the register file
- RegWriteW  in  1  Writeback instruction writes the register file
- ResultSrcE  in  2  result select in Execute; 2'b01 marks a load
- PCSrcE  in  1  branch taken or jump resolved in Execute
- MemReqM  in  1  load/store active in Memory
- MemReadyM  in  1  data memory completes this cycle
- cnt_clr  in  1  synchronous clear of both counters
- ForwardAE  out  2  SrcA select: 00 = RD1E, 01 = ResultW, 10 = ALUResultM
- ForwardBE  out  2  SrcB select, same encoding as ForwardAE
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID
- StallE  out  1  hold ID/EX
- StallM  out  1  hold EX/MEM
- FlushD  out  1  clear IF/ID
- FlushE  out  1  clear ID/EX (bubble)
- mem_timeout  out  1  sticky flag: memory wait exceeded WAIT_MAX
- stall_cnt  out  CNT_W  cycles with StallF high
- flush_cnt  out  CNT_W  cycles with a branch/jump-caused FlushE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = RUN; wait_cnt, stall_cnt, flush_cnt = 0; mem_timeout = 0.
  - While rst_n is low, combinational outputs are forced: FlushD = FlushE = 1, all stalls = 0, ForwardAE/BE = 00.
- Forwarding (combinational, applied in every state):
  - ForwardAE = 10 if RegWriteM, RdM != 0 and RdM == Rs1E.
  - Otherwise 01 if RegWriteW, RdW != 0 and RdW == Rs1E.
  - Otherwise 00.
  - Memory has priority over Writeback. ForwardBE follows the same rules with Rs2E.
- Derived conditions:
  - memwait = MemReqM & ~MemReadyM
  - lwStall = (ResultSrcE == 2'b01) & RegWriteE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D)
- Priority (highest first): reset > memwait > PCSrcE > lwStall.
- When memwait = 1 (any state):
  - StallF = StallD = StallE = StallM = 1; FlushD = FlushE = 0.
  - A pending PCSrcE is held in Execute and its flush is applied in the first cycle after release.
- When memwait = 0:
  - StallE = StallM = 0.
  - StallF = StallD = lwStall & ~PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE | lwStall.
- Invariant: a stall and a flush are never asserted on the same register in the same cycle.
- FSM:
  - RUN → WAIT when memwait = 1; wait_cnt <= 1.
  - WAIT stays in WAIT while memwait = 1; wait_cnt increments, saturating at WAIT_MAX.
  - When wait_cnt reaches WAIT_MAX, mem_timeout <= 1 (sticky until reset). Stalling continues; no forced release.
  - WAIT → RUN when MemReadyM = 1 or MemReqM = 0; wait_cnt <= 0.
  - Entry into WAIT is not delayed: outputs depend on memwait, not on state.
- Counters:
  - stall_cnt increments each cycle StallF = 1.
  - flush_cnt increments each cycle FlushE = 1 with PCSrcE = 1 and memwait = 0.
  - Both saturate at 2^CNT_W - 1.
  - cnt_clr has priority over increment; clearing in the same cycle as an event leaves the counter at 0.
- Reset mid-wait: state returns to RUN immediately; the memory request is not tracked after reset.

Decomposition:
- Shared package riscv_pipe_pkg:
  - FWD_RD = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - RES_SRC_MEM = 2'b01.
  - Hazard state encoding: RUN, WAIT.
- One sub-module, forward_unit: purely combinational; produces ForwardAE/ForwardBE from Rs1E, Rs2E, RdM, RdW, RegWriteM, RegWriteW.
- Stall/flush logic, FSM and counters stay in pipeline_hazard_ctrl.

Test Plan:
- Rs1E = 5, RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1 → ForwardAE = 10. Same with RdM = 0 → ForwardAE = 01.
- Load in E (ResultSrcE = 01, RdE = 7, RegWriteE = 1) with Rs2D = 7 → StallF = StallD = 1, FlushE = 1 for exactly one cycle; stall_cnt = 1.
- PCSrcE = 1 together with lwStall = 1 → FlushD = FlushE = 1, StallF = 0; flush_cnt increments by 1.
- MemReqM = 1, MemReadyM = 0 for 3 cycles, PCSrcE = 1 throughout → all four stalls = 1 and no flush for 3 cycles. Cycle 4 (ready) → FlushD = FlushE = 1; state returns to RUN.
- WAIT_MAX = 4, memory never ready → mem_timeout rises after the 4th wait cycle and remains 1 after MemReadyM = 1.
- Assert rst_n low during WAIT, then release → state RUN, counters 0, mem_timeout 0. cnt_clr with stall_cnt = 2^CNT_W - 1 → 0.
